// File: rtl/hermes_clksrc_supervisor_pkg.sv
// Shared types and width helpers for the Hermes clock-source supervisor.
// Latency: none (types and constant functions only).
// Backpressure: none.
package hermes_clksrc_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_SELECT    = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } sup_state_t;

    // $clog2 that never returns 0, so single-entry vectors still get one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hermes_clksrc_supervisor_debounce.sv
// Two-flop synchroniser plus stability counter for one external clock-source valid flag.
// Latency: 2 sync cycles + 2**DEB_W-1 stable cycles + 2 before deb_valid follows the input.
// Backpressure: none; free-running on rstclk.
//
// Ports: rstclk / extreset (async active-low), din (async source flag), deb_valid (debounced level).
module hermes_clksrc_supervisor_debounce #(
    parameter int DEB_W = 16
) (
    input  logic rstclk,
    input  logic extreset,
    input  logic din,
    output logic deb_valid
);

    logic [1:0]       sync_q;
    logic             last_q;
    logic [DEB_W-1:0] cnt_q;

    always_ff @(posedge rstclk or negedge extreset) begin
        if (!extreset) begin
            sync_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            deb_valid <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            last_q <= sync_q[1];
            // Any edge restarts the stability window; the debounced level
            // only moves once the counter has saturated.
            if (sync_q[1] != last_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + DEB_W'(1);
            end else begin
                deb_valid <= last_q;
            end
        end
    end

endmodule

// File: rtl/hermes_clksrc_supervisor.sv
// Clock-source and staged-reset supervisor: picks an AD9866 clock source, drives the mux select, sequences core resets.
// Latency: SETTLE cycles from mux select to first release, then STAGE cycles per further domain.
// Backpressure: none; any loss of the selected source or of PLL lock immediately re-asserts all resets.
//
// Ports: rstclk, extreset (async active-low), pll_locked / src_valid / force_en / force_sel (async inputs),
//        clkselect (mux select), core_rst_n (per-domain resets), active_src, running, switch_cnt, fault.
module hermes_clksrc_supervisor
    import hermes_clksrc_supervisor_pkg::*;
#(
    parameter int NSRC     = 4,
    parameter int NRST     = 3,
    parameter int DEB_W    = 16,
    parameter int SETTLE   = 1024,
    parameter int STAGE    = 64,
    parameter int AUTO_REV = 1
) (
    input  logic                        rstclk,
    input  logic                        extreset,
    input  logic                        pll_locked,
    input  logic [NSRC-1:0]             src_valid,
    input  logic                        force_en,
    input  logic [clog2_min1(NSRC)-1:0] force_sel,
    output logic [clog2_min1(NSRC)-1:0] clkselect,
    output logic [NRST-1:0]             core_rst_n,
    output logic [clog2_min1(NSRC)-1:0] active_src,
    output logic                        running,
    output logic [7:0]                  switch_cnt,
    output logic                        fault
);

    localparam int SW = clog2_min1(NSRC);
    localparam int CW = $clog2(max2(SETTLE, STAGE)) + 1;
    localparam int KW = clog2_min1(NRST) + 1;

    localparam logic [SW-1:0] FALLBACK    = SW'(NSRC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE - 1);
    localparam logic [KW-1:0] LAST_DOM    = KW'(NRST - 1);

    // ---------------------------------------------------------------
    // Synchronisers for the control inputs
    // ---------------------------------------------------------------
    logic          pll_q1, pll_s, pll_q;
    logic          fen_q1, force_en_s;
    logic [SW-1:0] fsel_q1, force_sel_s;

    always_ff @(posedge rstclk or negedge extreset) begin
        if (!extreset) begin
            pll_q1      <= 1'b0;
            pll_s       <= 1'b0;
            pll_q       <= 1'b0;
            fen_q1      <= 1'b0;
            force_en_s  <= 1'b0;
            fsel_q1     <= '0;
            force_sel_s <= '0;
        end else begin
            pll_q1      <= pll_locked;
            pll_s       <= pll_q1;
            pll_q       <= pll_s;
            fen_q1      <= force_en;
            force_en_s  <= fen_q1;
            fsel_q1     <= force_sel;
            force_sel_s <= fsel_q1;
        end
    end

    // ---------------------------------------------------------------
    // Per-source validity: external sources debounced, fallback = PLL lock
    // ---------------------------------------------------------------
    logic [NSRC-1:0] src_ok;

    for (genvar g = 0; g < NSRC - 1; g++) begin : g_deb
        hermes_clksrc_supervisor_debounce #(
            .DEB_W (DEB_W)
        ) u_deb (
            .rstclk    (rstclk),
            .extreset  (extreset),
            .din       (src_valid[g]),
            .deb_valid (src_ok[g])
        );
    end

    assign src_ok[NSRC-1] = pll_s;

    // The top src_valid bit has no external source behind it.
    logic unused_src;
    assign unused_src = src_valid[NSRC-1];

    // ---------------------------------------------------------------
    // Target selection
    // ---------------------------------------------------------------
    logic [SW-1:0] fsel_eff;
    logic [SW-1:0] prio_sel;
    logic [SW-1:0] target;

    always_comb begin
        fsel_eff = force_sel_s;
        if (int'(force_sel_s) >= NSRC) begin
            fsel_eff = FALLBACK;
        end
        prio_sel = FALLBACK;
        for (int i = NSRC - 2; i >= 0; i--) begin
            if (src_ok[i]) begin
                prio_sel = SW'(i);
            end
        end
        target = prio_sel;
        if (force_en_s) begin
            target = src_ok[fsel_eff] ? fsel_eff : FALLBACK;
        end
    end

    logic sel_lost;
    logic want_move;
    logic pll_fall;

    assign sel_lost  = !src_ok[active_src];
    assign want_move = (target != active_src) && ((AUTO_REV != 0) || force_en_s || sel_lost);
    assign pll_fall  = pll_q && !pll_s;

    // ---------------------------------------------------------------
    // Supervisor FSM with shared settle/stage counter
    // ---------------------------------------------------------------
    sup_state_t    state;
    logic [CW-1:0] cnt;
    logic [KW-1:0] rel_k;

    always_ff @(posedge rstclk or negedge extreset) begin
        if (!extreset) begin
            state      <= ST_WAIT_LOCK;
            cnt        <= '0;
            rel_k      <= '0;
            clkselect  <= FALLBACK;
            active_src <= FALLBACK;
            core_rst_n <= '0;
            running    <= 1'b0;
            switch_cnt <= 8'd0;
            fault      <= 1'b0;
        end else if (pll_fall) begin
            // Lock loss overrides everything and is remembered until extreset.
            state      <= ST_WAIT_LOCK;
            core_rst_n <= '0;
            running    <= 1'b0;
            fault      <= 1'b1;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    core_rst_n <= '0;
                    running    <= 1'b0;
                    if (pll_s) begin
                        state <= ST_SELECT;
                    end
                end

                // Resets are already low here, so the mux can move safely.
                ST_SELECT: begin
                    clkselect  <= target;
                    active_src <= target;
                    if ((target != active_src) && (switch_cnt != 8'hFF)) begin
                        switch_cnt <= switch_cnt + 8'd1;
                    end
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (sel_lost) begin
                        core_rst_n <= '0;
                        running    <= 1'b0;
                        state      <= ST_SELECT;
                    end else if (cnt == SETTLE_LAST) begin
                        cnt           <= '0;
                        core_rst_n[0] <= 1'b1;
                        if (NRST == 1) begin
                            running <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            rel_k <= KW'(1);
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_RELEASE: begin
                    // No partial release survives a lost source.
                    if (sel_lost) begin
                        core_rst_n <= '0;
                        running    <= 1'b0;
                        state      <= ST_SELECT;
                    end else if (cnt == STAGE_LAST) begin
                        cnt        <= '0;
                        core_rst_n <= core_rst_n | (NRST'(1) << rel_k);
                        if (rel_k == LAST_DOM) begin
                            running <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            rel_k <= rel_k + KW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                ST_RUN: begin
                    if (sel_lost || want_move) begin
                        core_rst_n <= '0;
                        running    <= 1'b0;
                        state      <= ST_SELECT;
                    end
                end

                default: begin
                    core_rst_n <= '0;
                    running    <= 1'b0;
                    state      <= ST_WAIT_LOCK;
                end
            endcase
        end
    end

endmodule
